// File: rtl/lu_rr_arbiter_if.sv
// Handshake bundle between two logic-unit requesters, the round-robin arbiter and the result consumer.
interface lu_rr_arbiter_if #(
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_x;
    logic [DW-1:0] req0_y;
    logic [1:0]    req0_op;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_x;
    logic [DW-1:0] req1_y;
    logic [1:0]    req1_op;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_f;
    logic          res_id;
    logic          busy;

    modport master (
        output req0_valid, req0_x, req0_y, req0_op,
        input  req0_ready,
        output req1_valid, req1_x, req1_y, req1_op,
        input  req1_ready,
        input  res_valid, res_f, res_id, busy,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_op,
        output req0_ready,
        input  req1_valid, req1_x, req1_y, req1_op,
        output req1_ready,
        output res_valid, res_f, res_id, busy,
        input  res_ready
    );
endinterface

// File: rtl/lu_rr_arbiter.sv
// Round-robin share of one 8-bit logic unit between two requesters; result registered 1 cycle after accept.
// Result held (both readies low) until res_ready; max one op per 2 cycles.
module lu_rr_arbiter #(
    parameter int DW        = 8,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    lu_rr_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ptr;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] lu_x;
    logic [DW-1:0] lu_y;
    logic [1:0]    lu_op;
    logic [DW-1:0] lu_f;
    logic [DW-1:0] res_f_q;
    logic          res_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ptr only breaks ties; a lone valid requester always wins.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                gnt0 = bus.req0_valid && (!bus.req1_valid || !ptr);
                gnt1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
                if (gnt0 || gnt1) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lu_x  = gnt1 ? bus.req1_x  : bus.req0_x;
        lu_y  = gnt1 ? bus.req1_y  : bus.req0_y;
        lu_op = gnt1 ? bus.req1_op : bus.req0_op;
        case (lu_op)
            2'b00:   lu_f = lu_x | lu_y;
            2'b01:   lu_f = lu_x & lu_y;
            2'b10:   lu_f = lu_x ^ lu_y;
            default: lu_f = ~lu_x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= (PRIO_INIT != 0);
            res_f_q  <= '0;
            res_id_q <= 1'b0;
        end else if (gnt0 || gnt1) begin
            res_f_q  <= lu_f;
            res_id_q <= gnt1;
            ptr      <= !gnt1;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.res_valid  = (state == HOLD);
    assign bus.busy       = (state == HOLD);
    assign bus.res_f      = res_f_q;
    assign bus.res_id     = res_id_q;
endmodule
